// File: rtl/fpu_mult_pipe.sv
// Three-stage pipelined IEEE-754 multiplier: unpack + low partial product, accumulate,
// normalise/round-to-nearest-even. Subnormals are flushed; special operands bypass rounding.
module fpu_mult_pipe #(
  parameter int unsigned EXP_W   = 8,
  parameter int unsigned MAN_W   = 23,
  parameter int unsigned SPLIT_W = 12
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_in_valid,
  output logic                     o_in_ready,
  input  logic [EXP_W+MAN_W:0]     i_op_a,
  input  logic [EXP_W+MAN_W:0]     i_op_b,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic [EXP_W+MAN_W:0]     o_result,
  output logic [3:0]               o_flags
);
  localparam int unsigned W  = 1 + EXP_W + MAN_W;
  localparam int unsigned SW = MAN_W + 1;
  localparam int unsigned PW = 2 * MAN_W + 2;
  localparam int unsigned LW = SW + SPLIT_W;
  localparam int unsigned HW = SW - SPLIT_W;
  localparam int unsigned XW = EXP_W + 2;
  localparam logic [XW-1:0] Bias   = XW'((1 << (EXP_W - 1)) - 1);
  localparam logic [XW-1:0] ExpMax = XW'((1 << EXP_W) - 1);

  typedef enum logic [1:0] {KdNum, KdNan, KdInf, KdZero} kind_e;

  logic r_v1, r_v2, r_v3;
  logic w_advance;
  assign w_advance   = !r_v3 || i_out_ready;
  assign o_in_ready  = w_advance;
  assign o_out_valid = r_v3;

  // S1: operand decode
  logic [EXP_W-1:0] w_ea, w_eb;
  logic [MAN_W-1:0] w_fa, w_fb;
  logic [SW-1:0]    w_sig_a, w_sig_b;
  logic w_zero_a, w_zero_b, w_inf_a, w_inf_b, w_nan_a, w_nan_b, w_snan_a, w_snan_b, w_zxi;
  assign w_ea     = i_op_a[MAN_W +: EXP_W];
  assign w_eb     = i_op_b[MAN_W +: EXP_W];
  assign w_fa     = i_op_a[MAN_W-1:0];
  assign w_fb     = i_op_b[MAN_W-1:0];
  assign w_sig_a  = {1'b1, w_fa};
  assign w_sig_b  = {1'b1, w_fb};
  assign w_zero_a = (w_ea == '0);
  assign w_zero_b = (w_eb == '0);
  assign w_inf_a  = (&w_ea) && (w_fa == '0);
  assign w_inf_b  = (&w_eb) && (w_fb == '0);
  assign w_nan_a  = (&w_ea) && (w_fa != '0);
  assign w_nan_b  = (&w_eb) && (w_fb != '0);
  assign w_snan_a = w_nan_a && !w_fa[MAN_W-1];
  assign w_snan_b = w_nan_b && !w_fb[MAN_W-1];
  assign w_zxi    = (w_zero_a && w_inf_b) || (w_inf_a && w_zero_b);

  kind_e w_kind;
  logic  w_inv;
  always_comb begin
    w_kind = KdNum;
    w_inv  = 1'b0;
    if (w_nan_a || w_nan_b || w_zxi) begin
      w_kind = KdNan;
      w_inv  = w_snan_a || w_snan_b || w_zxi;
    end else if (w_inf_a || w_inf_b) begin
      w_kind = KdInf;
    end else if (w_zero_a || w_zero_b) begin
      w_kind = KdZero;
    end
  end

  logic [XW-1:0] w_exp_sum;
  logic [LW-1:0] w_plo;
  assign w_exp_sum = XW'(w_ea) + XW'(w_eb) - Bias;
  assign w_plo     = LW'(w_sig_a) * LW'(w_sig_b[SPLIT_W-1:0]);

  logic [SW-1:0] r1_sig_a;
  logic [HW-1:0] r1_sig_b_hi;
  logic [LW-1:0] r1_plo;
  logic [XW-1:0] r1_exp;
  logic          r1_sign, r1_inv;
  kind_e         r1_kind;

  // S2: accumulate the high partial product
  logic [PW-1:0] w_prod;
  assign w_prod = ((PW'(r1_sig_a) * PW'(r1_sig_b_hi)) << SPLIT_W) + PW'(r1_plo);

  logic [PW-1:0] r2_prod;
  logic [XW-1:0] r2_exp;
  logic          r2_sign, r2_inv;
  kind_e         r2_kind;

  // S3: normalise to 1.f (hidden bit dropped), then RNE on the fraction
  logic          w_norm, w_guard, w_sticky, w_rnd, w_carry, w_inexact, w_of, w_uf;
  logic [PW-2:0] w_shp;
  logic [MAN_W:0] w_frac_r;
  logic [XW-1:0] w_exp_f;
  assign w_norm    = r2_prod[PW-1];
  assign w_shp     = w_norm ? r2_prod[PW-2:0] : {r2_prod[PW-3:0], 1'b0};
  assign w_guard   = w_shp[MAN_W];
  assign w_sticky  = |w_shp[MAN_W-1:0];
  assign w_rnd     = w_guard && (w_sticky || w_shp[MAN_W+1]);
  assign w_frac_r  = {1'b0, w_shp[PW-2 -: MAN_W]} + (MAN_W+1)'(w_rnd);
  assign w_carry   = w_frac_r[MAN_W];
  assign w_exp_f   = r2_exp + XW'(w_norm) + XW'(w_carry);
  assign w_inexact = w_guard || w_sticky;
  assign w_uf      = w_exp_f[XW-1] || (w_exp_f == '0);
  assign w_of      = !w_exp_f[XW-1] && (w_exp_f >= ExpMax);

  logic [W-1:0] w_res;
  logic [3:0]   w_flg;
  always_comb begin
    w_res = {r2_sign, w_exp_f[EXP_W-1:0], w_frac_r[MAN_W-1:0]};
    w_flg = {3'b000, w_inexact};
    case (r2_kind)
      KdNan: begin
        w_res = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
        w_flg = {r2_inv, 3'b000};
      end
      KdInf: begin
        w_res = {r2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        w_flg = 4'b0000;
      end
      KdZero: begin
        w_res = {r2_sign, {(W-1){1'b0}}};
        w_flg = 4'b0000;
      end
      default: begin
        if (w_of) begin
          w_res = {r2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          w_flg = 4'b0101;
        end else if (w_uf) begin
          w_res = {r2_sign, {(W-1){1'b0}}};
          w_flg = 4'b0011;
        end
      end
    endcase
  end

  logic [W-1:0] r_res;
  logic [3:0]   r_flg;
  assign o_result = r_res;
  assign o_flags  = r_flg;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_v1 <= 1'b0; r_v2 <= 1'b0; r_v3 <= 1'b0;
      r1_sig_a <= '0; r1_sig_b_hi <= '0; r1_plo <= '0; r1_exp <= '0;
      r1_sign <= 1'b0; r1_inv <= 1'b0; r1_kind <= KdNum;
      r2_prod <= '0; r2_exp <= '0; r2_sign <= 1'b0; r2_inv <= 1'b0; r2_kind <= KdNum;
      r_res <= '0; r_flg <= '0;
    end else if (w_advance) begin
      r_v1 <= i_in_valid; r_v2 <= r_v1; r_v3 <= r_v2;
      r1_sig_a    <= w_sig_a;
      r1_sig_b_hi <= w_sig_b[MAN_W:SPLIT_W];
      r1_plo      <= w_plo;
      r1_exp      <= w_exp_sum;
      r1_sign     <= i_op_a[W-1] ^ i_op_b[W-1];
      r1_inv      <= w_inv;
      r1_kind     <= w_kind;
      r2_prod     <= w_prod;
      r2_exp      <= r1_exp;
      r2_sign     <= r1_sign;
      r2_inv      <= r1_inv;
      r2_kind     <= r1_kind;
      r_res       <= w_res;
      r_flg       <= w_flg;
    end
  end
endmodule

// File: tb/tb_fpu_mult_pipe.sv
// Directed bench for fpu_mult_pipe: single- and half-precision instances, vector table,
// back-to-back latency, random backpressure stream and mid-flight reset.
module tb_fpu_mult_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, out_ready, in_ready, out_valid;
  logic [31:0] op_a, op_b, result;
  logic [3:0]  flags;
  logic        h_rst, h_in_valid, h_out_ready, h_in_ready, h_out_valid;
  logic [15:0] h_op_a, h_op_b, h_result;
  logic [3:0]  h_flags;

  fpu_mult_pipe #(.EXP_W(8), .MAN_W(23), .SPLIT_W(12)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_op_a(op_a), .i_op_b(op_b), .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_result(result), .o_flags(flags)
  );

  fpu_mult_pipe #(.EXP_W(5), .MAN_W(10), .SPLIT_W(5)) u_half (
    .i_clk(clk), .i_rst(h_rst), .i_in_valid(h_in_valid), .o_in_ready(h_in_ready),
    .i_op_a(h_op_a), .i_op_b(h_op_b), .o_out_valid(h_out_valid), .i_out_ready(h_out_ready),
    .o_result(h_result), .o_flags(h_flags)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  flg;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  logic [31:0] q_res[$];
  logic [3:0]  q_flg[$];

  initial begin
    int sent, got, n;
    logic stall_prev;
    logic [31:0] held_r;
    logic [3:0]  held_f;

    vecs[0]  = '{32'h40000000, 32'h40400000, 32'h40C00000, 4'b0000};
    vecs[1]  = '{32'hC0000000, 32'h40400000, 32'hC0C00000, 4'b0000};
    vecs[2]  = '{32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001};
    vecs[3]  = '{32'h3FC00000, 32'h3FC00000, 32'h40100000, 4'b0000};
    vecs[4]  = '{32'h7F000000, 32'h40000000, 32'h7F800000, 4'b0101};
    vecs[5]  = '{32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011};
    vecs[6]  = '{32'h00000000, 32'h7F800000, 32'h7FC00000, 4'b1000};
    vecs[7]  = '{32'h7FA00000, 32'h3F800000, 32'h7FC00000, 4'b1000};
    vecs[8]  = '{32'h7FC00000, 32'h3F800000, 32'h7FC00000, 4'b0000};
    vecs[9]  = '{32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000};
    vecs[10] = '{32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'b0001};  // guard, lsb=1: up
    vecs[11] = '{32'h3F800003, 32'h3FC00000, 32'h3FC00004, 4'b0001};  // tie, lsb=0: hold
    vecs[12] = '{32'h3F800001, 32'h3FFFFFFE, 32'h40000000, 4'b0001};  // round carry-out
    vecs[13] = '{32'h80000000, 32'h40000000, 32'h80000000, 4'b0000};
    vecs[14] = '{32'h00000001, 32'h40000000, 32'h00000000, 4'b0000};  // subnormal as zero

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op_a = '0; op_b = '0;
    h_rst = 1'b1; h_in_valid = 1'b0; h_out_ready = 1'b1; h_op_a = '0; h_op_b = '0;
    repeat (2) @(negedge clk);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset result", result, 32'd0);
    check("reset flags", 32'(flags), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("half reset out_valid", 32'(h_out_valid), 32'd0);
    rst = 1'b0; h_rst = 1'b0;

    // Back-to-back pair: results on consecutive cycles, exact latency
    @(negedge clk);
    in_valid = 1'b1; op_a = vecs[0].a; op_b = vecs[0].b;
    @(negedge clk);
    op_a = vecs[1].a; op_b = vecs[1].b;
    @(negedge clk);
    in_valid = 1'b0;
    check("b2b early valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("b2b valid0", 32'(out_valid), 32'd1);
    check("b2b res0", result, vecs[0].res);
    check("b2b flg0", 32'(flags), 32'(vecs[0].flg));
    @(negedge clk);
    check("b2b valid1", 32'(out_valid), 32'd1);
    check("b2b res1", result, vecs[1].res);
    check("b2b flg1", 32'(flags), 32'(vecs[1].flg));
    @(negedge clk);
    check("b2b drained", 32'(out_valid), 32'd0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      in_valid = 1'b1; op_a = vecs[i].a; op_b = vecs[i].b;
      @(negedge clk);
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 8) begin
        @(negedge clk);
        n++;
      end
      check($sformatf("vec%0d valid", i), 32'(out_valid), 32'd1);
      check($sformatf("vec%0d res", i), result, vecs[i].res);
      check($sformatf("vec%0d flags", i), 32'(flags), 32'(vecs[i].flg));
    end
    @(negedge clk);

    // Stream with random backpressure
    sent = 0; got = 0; stall_prev = 1'b0; held_r = '0; held_f = '0;
    for (int cyc = 0; cyc < 300 && got < 10; cyc++) begin
      @(negedge clk);
      out_ready = ($urandom_range(0, 1) == 1);
      in_valid = (sent < 10);
      if (sent < 10) begin
        op_a = vecs[sent].a; op_b = vecs[sent].b;
      end
      #1;
      if (stall_prev) begin
        check("stream hold valid", 32'(out_valid), 32'd1);
        check("stream hold res", result, held_r);
        check("stream hold flags", 32'(flags), 32'(held_f));
      end
      check("stream in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
      if (out_valid && out_ready) begin
        if (q_res.size() == 0) begin
          check("stream spurious output", 32'(q_res.size()), 32'd1);
        end else begin
          check($sformatf("stream res%0d", got), result, q_res.pop_front());
          check($sformatf("stream flags%0d", got), 32'(flags), 32'(q_flg.pop_front()));
        end
        got++;
      end
      stall_prev = out_valid && !out_ready;
      held_r = result; held_f = flags;
      if (in_valid && in_ready) begin
        q_res.push_back(vecs[sent].res);
        q_flg.push_back(vecs[sent].flg);
        sent++;
      end
    end
    check("stream count", 32'(got), 32'd10);
    check("stream leftover", 32'(q_res.size()), 32'd0);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) @(negedge clk);

    // Reset with three ops in flight
    in_valid = 1'b1; op_a = vecs[2].a; op_b = vecs[2].b;
    @(negedge clk);
    op_a = vecs[3].a; op_b = vecs[3].b;
    @(negedge clk);
    op_a = vecs[4].a; op_b = vecs[4].b;
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst flush valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("rst no stale %0d", i), 32'(out_valid), 32'd0);
    end
    in_valid = 1'b1; op_a = vecs[0].a; op_b = vecs[0].b;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("post-rst early valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("post-rst valid", 32'(out_valid), 32'd1);
    check("post-rst res", result, vecs[0].res);

    // Half precision: in-flight op discarded by reset, then a fresh op
    @(negedge clk);
    h_in_valid = 1'b1; h_op_a = 16'h4000; h_op_b = 16'h4200;
    @(negedge clk);
    h_in_valid = 1'b0; h_rst = 1'b1;
    @(negedge clk);
    h_rst = 1'b0;
    check("half rst flush", 32'(h_out_valid), 32'd0);
    repeat (3) @(negedge clk);
    check("half no stale", 32'(h_out_valid), 32'd0);
    h_in_valid = 1'b1;
    @(negedge clk);
    h_in_valid = 1'b0;
    @(negedge clk);
    check("half early valid", 32'(h_out_valid), 32'd0);
    @(negedge clk);
    check("half valid", 32'(h_out_valid), 32'd1);
    check("half res", 32'(h_result), 32'h4600);
    check("half flags", 32'(h_flags), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
